// File: rtl/cond_flags_if.sv
// NZCV flag / IT-block interface between the ALU/retire logic (master)
// and the condition-flag consumer (slave).
interface cond_flags_if;
  logic       n_in;
  logic       z_in;
  logic       c_in;
  logic       v_in;
  logic       flag_we;
  logic       instr_adv;
  logic       it_load;
  logic [3:0] it_cond;
  logic [3:0] it_mask;
  logic [3:0] cond_ext;
  logic       n;
  logic       z;
  logic       c;
  logic       v;
  logic       in_it;
  logic       it_last;
  logic       cond_pass;
  logic       it_err;

  modport master (
    output n_in, z_in, c_in, v_in, flag_we, instr_adv, it_load,
           it_cond, it_mask, cond_ext,
    input  n, z, c, v, in_it, it_last, cond_pass, it_err
  );

  modport slave (
    input  n_in, z_in, c_in, v_in, flag_we, instr_adv, it_load,
           it_cond, it_mask, cond_ext,
    output n, z, c, v, in_it, it_last, cond_pass, it_err
  );
endinterface

// File: rtl/cond_flags_it.sv
// Architectural NZCV flag register, Thumb ITSTATE tracking and ARM
// condition-code evaluation for issue/retire.
module cond_flags_it #(
  parameter logic [3:0] FLAGS_RESET = 4'b0000
) (
  input logic         clk,
  input logic         rst,
  cond_flags_if.slave bus
);

  logic [3:0] flags;
  logic [7:0] itstate;
  logic       it_err_q;

  logic       in_it;
  logic       it_last;
  logic [3:0] ec;
  logic       pass;
  logic       load_ok;
  logic       load_rej;

  // ARM condition table evaluated against {n,z,c,v}
  function automatic logic cond_eval(input logic [3:0] cond, input logic [3:0] f);
    logic fn, fz, fc, fv;
    logic r;
    {fn, fz, fc, fv} = f;
    case (cond)
      4'b0000: r = fz;
      4'b0001: r = !fz;
      4'b0010: r = fc;
      4'b0011: r = !fc;
      4'b0100: r = fn;
      4'b0101: r = !fn;
      4'b0110: r = fv;
      4'b0111: r = !fv;
      4'b1000: r = fc & !fz;
      4'b1001: r = !fc | fz;
      4'b1010: r = (fn == fv);
      4'b1011: r = (fn != fv);
      4'b1100: r = !fz & (fn == fv);
      4'b1101: r = fz | (fn != fv);
      default: r = 1'b1;
    endcase
    return r;
  endfunction

  // Decode ITSTATE, pick the effective condition and classify IT loads
  always_comb begin
    in_it    = (itstate[3:0] != 4'b0000);
    it_last  = in_it & (itstate[2:0] == 3'b000);
    if (in_it) begin
      ec = itstate[7:4];
    end else begin
      ec = bus.cond_ext;
    end
    pass     = cond_eval(ec, flags);
    load_ok  = bus.it_load & !in_it & (bus.it_mask != 4'b0000);
    load_rej = bus.it_load & !load_ok;
  end

  // Flag register, ITSTATE and the rejected-load pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      flags    <= FLAGS_RESET;
      itstate  <= 8'h00;
      it_err_q <= 1'b0;
    end else begin
      it_err_q <= load_rej;
      if (bus.flag_we && pass) begin
        flags <= {bus.n_in, bus.z_in, bus.c_in, bus.v_in};
      end else begin
        flags <= flags;
      end
      // An accepted load swallows a same-cycle advance; a failing instruction still uses its slot
      if (load_ok) begin
        itstate <= {bus.it_cond, bus.it_mask};
      end else if (bus.instr_adv && in_it) begin
        if (itstate[2:0] == 3'b000) begin
          itstate <= 8'h00;
        end else begin
          itstate[4:0] <= {itstate[3:0], 1'b0};
        end
      end else begin
        itstate <= itstate;
      end
    end
  end

  assign bus.n         = flags[3];
  assign bus.z         = flags[2];
  assign bus.c         = flags[1];
  assign bus.v         = flags[0];
  assign bus.in_it     = in_it;
  assign bus.it_last   = it_last;
  assign bus.cond_pass = pass;
  assign bus.it_err    = it_err_q;

endmodule

// File: tb/tb_cond_flags_it.sv
// Scoreboard bench for cond_flags_it: directed steps queue expected output
// vectors {n,z,c,v,in_it,it_last,cond_pass,it_err}; a negedge monitor checks them.
module tb_cond_flags_it;
  logic clk;
  logic rst;
  int   checks;
  int   errors;

  typedef struct {
    string      name;
    logic [7:0] val;
  } exp_t;

  exp_t q[$];

  cond_flags_if bus();

  cond_flags_it #(.FLAGS_RESET(4'b0000)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] obs;
  assign obs = {bus.n, bus.z, bus.c, bus.v, bus.in_it, bus.it_last, bus.cond_pass, bus.it_err};

  // Monitor: compare every expectation queued for this cycle
  always @(negedge clk) begin
    exp_t e;
    while (q.size() != 0) begin
      e = q.pop_front();
      checks = checks + 1;
      if (obs !== e.val) begin
        errors = errors + 1;
        $display("FAIL %s: got %b expected %b (n z c v in_it it_last cond_pass it_err)",
                 e.name, obs, e.val);
      end
    end
  end

  task automatic expect_out(input string name, input logic [7:0] val);
    exp_t e;
    e.name = name;
    e.val  = val;
    q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    bus.n_in      = 1'b0;
    bus.z_in      = 1'b0;
    bus.c_in      = 1'b0;
    bus.v_in      = 1'b0;
    bus.flag_we   = 1'b0;
    bus.instr_adv = 1'b0;
    bus.it_load   = 1'b0;
    bus.it_cond   = 4'b0000;
    bus.it_mask   = 4'b0000;
    bus.cond_ext  = 4'b1110;
  endtask

  task automatic wr_flags(input logic [3:0] f);
    {bus.n_in, bus.z_in, bus.c_in, bus.v_in} = f;
    bus.flag_we = 1'b1;
  endtask

  task automatic load_it(input logic [3:0] cond, input logic [3:0] mask);
    bus.it_load = 1'b1;
    bus.it_cond = cond;
    bus.it_mask = mask;
  endtask

  initial begin
    int waited;
    checks = 0;
    errors = 0;
    rst = 1'b1;
    step();
    step();
    step();
    rst = 1'b0;
    expect_out("reset", 8'b0000_0010);
    wr_flags(4'b0110);                         // compare 5 vs 5
    step(); bus.cond_ext = 4'b0000; expect_out("eq_after_cmp", 8'b0110_0010);
    step(); bus.cond_ext = 4'b0001; expect_out("ne",           8'b0110_0000);
    step(); bus.cond_ext = 4'b1000; expect_out("hi",           8'b0110_0000);
    step(); bus.cond_ext = 4'b1010; expect_out("ge_equal",     8'b0110_0010);
    wr_flags(4'b1000);
    step(); bus.cond_ext = 4'b1011; expect_out("lt_n1v0",      8'b1000_0010);
    step(); bus.cond_ext = 4'b1010; expect_out("ge_n1v0",      8'b1000_0000);
    step(); bus.cond_ext = 4'b1100; expect_out("gt_n1v0",      8'b1000_0000);
    step(); bus.cond_ext = 4'b1101; expect_out("le_n1v0",      8'b1000_0010);
    wr_flags(4'b1001);
    step(); bus.cond_ext = 4'b1010; expect_out("ge_n1v1",      8'b1001_0010);
    step(); bus.cond_ext = 4'b0000; expect_out("eq_fails",     8'b1001_0000);
    wr_flags(4'b0000);                         // must be blocked: EQ fails
    step(); expect_out("blocked_write", 8'b1001_0010);
    wr_flags(4'b0100);
    step(); expect_out("z_set", 8'b0100_0010);
    load_it(4'b0000, 4'b0110);                 // ITTE EQ, same-cycle advance ignored
    bus.instr_adv = 1'b1;
    step(); bus.cond_ext = 4'b0001; bus.instr_adv = 1'b1; expect_out("itte_s1", 8'b0100_1010);
    step(); bus.instr_adv = 1'b1; expect_out("itte_s2", 8'b0100_1010);
    step(); bus.instr_adv = 1'b1; expect_out("itte_s3", 8'b0100_1100);
    step(); expect_out("itte_exit", 8'b0100_0010);
    load_it(4'b0001, 4'b1000);                 // IT NE, one slot
    step(); expect_out("ne_slot", 8'b0100_1100);
    wr_flags(4'b1100);
    bus.instr_adv = 1'b1;
    step(); expect_out("ne_noflag", 8'b0100_0010);
    load_it(4'b1110, 4'b0100);                 // two-slot AL block
    step(); expect_out("al_s1", 8'b0100_1010);
    load_it(4'b0001, 4'b1000);                 // nested load, rejected
    bus.instr_adv = 1'b1;
    step(); expect_out("nested_err", 8'b0100_1111);
    step(); bus.instr_adv = 1'b1; expect_out("err_clear", 8'b0100_1110);
    step(); expect_out("al_exit", 8'b0100_0010);
    load_it(4'b0000, 4'b0000);                 // zero mask, rejected
    step(); expect_out("mask0_err", 8'b0100_0011);
    step(); expect_out("mask0_clear", 8'b0100_0010);
    load_it(4'b0000, 4'b0001);                 // four-slot block
    step(); bus.instr_adv = 1'b1; expect_out("four_s1", 8'b0100_1010);
    step(); expect_out("four_s2", 8'b0100_1010);
    rst = 1'b1;
    wr_flags(4'b1000);
    step(); rst = 1'b0; expect_out("rst_mid", 8'b0000_0010);
    step(); bus.cond_ext = 4'b0000; expect_out("after_rst_eq", 8'b0000_0000);
    step();
    waited = 0;
    while (q.size() != 0 && waited < 20) begin
      @(posedge clk);
      waited = waited + 1;
    end
    if (q.size() != 0) begin
      checks = checks + 1;
      errors = errors + 1;
      $display("FAIL drain: %0d expectations left, required 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/cond_flags_it.md
# cond_flags_it

Consumer end of the NZCV flag interface. Holds the architectural flag register (APSR.NZCV) written from the compare/ALU flag outputs, tracks the Thumb IT-block state (ITSTATE), and evaluates the 4-bit condition code of the current instruction against the registered flags. It sits between the ALU flag outputs and the issue/retire logic: issue uses `cond_pass` to decide whether an instruction executes, and retire uses it to decide whether that instruction's flags are committed.

## Interface
- `FLAGS_RESET`, default 4'b0000: reset value of {n,z,c,v}.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `n_in`, `z_in`, `c_in`, `v_in` in 1 each: candidate flags from the ALU/compare unit.
- `flag_we` in 1: the current instruction is flag-setting.
- `instr_adv` in 1: one instruction retires this cycle and consumes one IT slot.
- `it_load` in 1: an IT instruction retires this cycle.
- `it_cond` in 4: firstcond of the IT instruction.
- `it_mask` in 4: mask of the IT instruction.
- `cond_ext` in 4: explicit condition of the current instruction (B<cond>). Drive 4'b1110 for unconditional instructions.
- `n`, `z`, `c`, `v` out 1 each: registered flags.
- `in_it` out 1: an IT block is active.
- `it_last` out 1: the current instruction is the last slot of the IT block.
- `cond_pass` out 1: the current instruction's condition is satisfied.
- `it_err` out 1: one-cycle pulse when an `it_load` request is rejected.

## Operation
- State registers:
  - `flags[3:0]` = {n,z,c,v}.
  - `itstate[7:0]`: bits [7:5] hold firstcond[3:1]; bits [4:0] hold the shifting IT field.
- Derived signals:
  - Current IT condition: `itc = itstate[7:4]`.
  - `in_it = (itstate[3:0] != 0)`.
  - `it_last = in_it & (itstate[2:0] == 0)`.
- Effective condition: `ec = in_it ? itc : cond_ext`. In an IT block, `cond_ext` is ignored.
- `cond_pass` is combinational from `ec` and the registered flags, per the ARM condition table:
  - 0000 EQ: z; 0001 NE: !z.
  - 0010 CS: c; 0011 CC: !c.
  - 0100 MI: n; 0101 PL: !n.
  - 0110 VS: v; 0111 VC: !v.
  - 1000 HI: c&!z; 1001 LS: !c|z.
  - 1010 GE: n==v; 1011 LT: n!=v.
  - 1100 GT: !z&(n==v); 1101 LE: z|(n!=v).
  - 1110 and 1111: always 1.
- Flag update: at a clock edge, if `flag_we & cond_pass`, then flags <= {n_in,z_in,c_in,v_in}. Otherwise the flags hold. `cond_pass` is evaluated on the pre-edge flags.
- IT load: the load is accepted when `it_load & !in_it & (it_mask != 0)`. Then itstate <= {it_cond, it_mask}.
  - The IT instruction itself does not consume a slot.
  - When a load is accepted, `instr_adv` in the same cycle is ignored.
- IT load rejected: when `it_load` is asserted while `in_it` is high, or with `it_mask == 0`:
  - itstate is not loaded;
  - `it_err` = 1 for the next cycle;
  - a simultaneous `instr_adv` is still applied.
- IT advance: applies when `instr_adv & in_it` and no load is accepted.
  - If itstate[2:0] == 0, then itstate <= 0 (the block exits).
  - Otherwise itstate[4:0] <= itstate[4:0] << 1, and bits [7:5] are unchanged.
  - Advance occurs whether or not `cond_pass` is high: a failing instruction still consumes its slot.
- When `instr_adv` is asserted outside an IT block, itstate is unchanged.
- Reset has priority over every other input. A reset in the middle of an IT block returns itstate to 0 on that edge.

## Timing
- Reset values: n/z/c/v = FLAGS_RESET, itstate = 0, in_it = 0, it_last = 0, it_err = 0.
- With default reset (flags 0000): `cond_pass` = 1 for cond 1110.
- Latency:
  - `cond_pass` has zero-cycle latency from `cond_ext`.
  - A flag write becomes visible on n/z/c/v one cycle after the `flag_we` edge.
  - A flag-setting instruction followed by a dependent conditional in the next cycle sees the new flags. There is no forwarding within the same cycle.
- `in_it`, `it_last` and `it_err` are registered; they change only on clock edges.
- An IT block with mask m covers 1 + (3 − position of the lowest 1 bit in m) instructions.

## Test plan
- Reset then compare 5 vs 5: with `n_in,z_in,c_in,v_in` = 0,1,1,0, `flag_we`=1 and `cond_ext`=1110, the next cycle reads z=1, c=1. Then `cond_ext`=0000 gives cond_pass=1; 0001 gives 0; 1000 (HI) gives 0; 1010 (GE) gives 1.
- Signed overflow: flags n=1, v=0 give LT=1, GE=0, GT=0, LE=1. Flags n=1, v=1 give GE=1.
- ITTE EQ: `it_cond`=0000, `it_mask`=0110, then 3× `instr_adv` with z=1.
  - `cond_pass` sequence is 1, 1, 0; `itc` sequence is 0000, 0000, 0001.
  - `it_last` is high only on the third slot; `in_it` drops after the third advance.
- Conditional flag write: in an IT NE block with z=1, an instruction with `flag_we`=1 and n_in=1 leaves the flags unchanged, and the slot is still consumed.
- Nested IT: with `in_it`=1, assert `it_load` (mask 1000) together with `instr_adv`. `it_err` pulses for 1 cycle, the old block advances normally, and itstate is not reloaded. `it_mask`=0000 outside a block also pulses `it_err`.
- Reset in the middle of an IT block after 1 of 4 slots: in_it=0 and flags=FLAGS_RESET on the next cycle, and `cond_ext`=1110 gives cond_pass=1.
